// File: rtl/dot_pkg.sv
// Shared constants and state encoding for the dot-product sequencer.
package dot_pkg;

    localparam int unsigned N_MAX      = 16;
    localparam int unsigned DW         = 8;
    localparam int unsigned AW         = $clog2(N_MAX);
    localparam int unsigned LW         = AW + 1;
    localparam int unsigned RW         = 16;
    localparam int unsigned MAC_SETTLE = 2;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WAIT1,
        WAIT2,
        DONE
    } state_e;

endpackage

// File: rtl/dot_seq_ctrl_if.sv
// Host-side bundle: operand write port, run control and captured result.
interface dot_seq_ctrl_if;
    import dot_pkg::*;

    logic          wr_en;
    logic          wr_sel;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [LW-1:0] vec_len;
    logic          start;
    logic          busy;
    logic          done;
    logic          err;
    logic [RW-1:0] result;
    logic          oflow;

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, vec_len, start,
        input  busy, done, err, result, oflow
    );

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, vec_len, start,
        output busy, done, err, result, oflow
    );

endinterface

// File: rtl/vec_regfile.sv
// N_MAX x DW operand store: synchronous write, asynchronous read.
module vec_regfile
    import dot_pkg::*;
(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata_c
);

    logic [DW-1:0] mem_q [N_MAX];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_c = mem_q[raddr];

endmodule

// File: rtl/dot_seq_ctrl.sv
// Sequencer for the 8x8 MAC: clears it, streams A/B element pairs, waits out
// the MAC latency and captures result and overflow.
module dot_seq_ctrl
    import dot_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    dot_seq_ctrl_if.slave       host,
    output logic                mac_rst,
    output logic                mac_enable,
    output logic [DW-1:0]       mac_a,
    output logic [DW-1:0]       mac_b,
    input  logic [RW-1:0]       mac_led,
    input  logic                mac_oflow
);

    state_e        state_q, state_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [RW-1:0] result_q, result_d;
    logic          oflow_q, oflow_d;
    logic          mac_rst_q, mac_rst_d;
    logic          mac_en_q, mac_en_d;
    logic [DW-1:0] mac_a_q, mac_a_d;
    logic [DW-1:0] mac_b_q, mac_b_d;

    logic          wr_ok_c;
    logic [DW-1:0] a_rd_c, b_rd_c;

    // Operand writes only land while idle.
    assign wr_ok_c = host.wr_en && (state_q == IDLE);

    vec_regfile u_vec_a (
        .clk     (clk),
        .we      (wr_ok_c && !host.wr_sel),
        .waddr   (host.wr_addr),
        .wdata   (host.wr_data),
        .raddr   (idx_q[AW-1:0]),
        .rdata_c (a_rd_c)
    );

    vec_regfile u_vec_b (
        .clk     (clk),
        .we      (wr_ok_c && host.wr_sel),
        .waddr   (host.wr_addr),
        .wdata   (host.wr_data),
        .raddr   (idx_q[AW-1:0]),
        .rdata_c (b_rd_c)
    );

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        err_d     = err_q;
        result_d  = result_q;
        oflow_d   = oflow_q;
        mac_rst_d = 1'b0;
        mac_en_d  = 1'b0;
        mac_a_d   = '0;
        mac_b_d   = '0;

        case (state_q)
            IDLE: begin
                if (host.start) begin
                    len_d = host.vec_len;
                    idx_d = '0;
                    if ((host.vec_len == '0) || (host.vec_len > LW'(N_MAX))) begin
                        state_d  = DONE;
                        done_d   = 1'b1;
                        err_d    = 1'b1;
                        result_d = '0;
                        oflow_d  = 1'b0;
                    end else begin
                        state_d   = CLEAR;
                        mac_rst_d = 1'b1;
                        err_d     = 1'b0;
                    end
                end
            end
            CLEAR, RUN: begin
                // idx_q counts pairs already issued; len_q issued means stream is over.
                if ((state_q == RUN) && (idx_q == len_q)) begin
                    state_d = WAIT1;
                end else begin
                    state_d  = RUN;
                    mac_en_d = 1'b1;
                    mac_a_d  = a_rd_c;
                    mac_b_d  = b_rd_c;
                    idx_d    = idx_q + LW'(1);
                end
            end
            WAIT1: state_d = WAIT2;
            WAIT2: begin
                state_d  = DONE;
                done_d   = 1'b1;
                result_d = mac_led;
                oflow_d  = mac_oflow;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            oflow_q   <= 1'b0;
            mac_rst_q <= 1'b0;
            mac_en_q  <= 1'b0;
            mac_a_q   <= '0;
            mac_b_q   <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            result_q  <= result_d;
            oflow_q   <= oflow_d;
            mac_rst_q <= mac_rst_d;
            mac_en_q  <= mac_en_d;
            mac_a_q   <= mac_a_d;
            mac_b_q   <= mac_b_d;
        end
    end

    // System reset reaches the MAC in the same cycle.
    assign mac_rst     = mac_rst_q | rst;
    assign mac_enable  = mac_en_q;
    assign mac_a       = mac_a_q;
    assign mac_b       = mac_b_q;
    assign host.busy   = busy_q;
    assign host.done   = done_q;
    assign host.err    = err_q;
    assign host.result = result_q;
    assign host.oflow  = oflow_q;

endmodule
